// File: rtl/qpsk_timing_ctrl_v2.sv
// qpsk_timing_ctrl_v2: CIC sample counter with BRAM write strobes, wrap/one-shot modes and marker time stamping.
// Define QPSK_TIMING_STAMP_EN to build the marker stamp logic; otherwise the stamp outputs are tied to zero.
module qpsk_timing_ctrl_v2 #(
  parameter int CNT_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cic_pulse,
  input  logic              clr,
  input  logic              mode,
  input  logic              arm,
  input  logic              marker_in,
  output logic [CNT_W-1:0]  cic_pulse_counter,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic              wrap_pulse,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  stamp,
  output logic              stamp_valid,
  input  logic              stamp_ack,
  output logic              stamp_overrun
);
  localparam int SUB_W = CNT_W - ADDR_W;
  localparam logic [CNT_W-1:0] SUB_MASK = ~({CNT_W{1'b1}} << SUB_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic term;
  assign cnt_inc = cnt + CNT_W'(1);
  assign term = &cnt;
  assign cic_pulse_counter = cnt;
  assign bram_addr = cnt[CNT_W-1:SUB_W];
  assign running = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bram_we <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clr) begin
        state <= IDLE;
        cnt <= '0;
      end else
        case (state)
          IDLE:
            if (!mode) state <= RUN;
            else if (arm) begin
              state <= RUN;
              cnt <= '0;
            end
          RUN:
            if (cic_pulse) begin
              // one-shot stops at terminal count and holds all-ones without a wrap
              if (term && mode) state <= DONE;
              else begin
                cnt <= cnt_inc;
                bram_we <= (cnt_inc & SUB_MASK) == '0;
                wrap_pulse <= term;
              end
            end
          DONE:
            if (arm) begin
              state <= RUN;
              cnt <= '0;
            end
          default: state <= IDLE;
        endcase
    end
`ifdef QPSK_TIMING_STAMP_EN
  logic marker_q, mark_rise;
  assign mark_rise = marker_in & ~marker_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      marker_q <= 1'b0;
      stamp <= '0;
      stamp_valid <= 1'b0;
      stamp_overrun <= 1'b0;
    end else begin
      marker_q <= marker_in;
      if (mark_rise && (!stamp_valid || stamp_ack)) begin
        stamp <= cnt;
        stamp_valid <= 1'b1;
      end else if (mark_rise) stamp_overrun <= 1'b1;
      else if (stamp_ack) stamp_valid <= 1'b0;
      if (clr) stamp_overrun <= 1'b0;
    end
`else
  logic unused_stamp_in;
  assign unused_stamp_in = marker_in ^ stamp_ack;
  assign stamp = '0;
  assign stamp_valid = 1'b0;
  assign stamp_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_qpsk_timing_ctrl_v2.sv
// tb_qpsk_timing_ctrl_v2: scoreboard bench for qpsk_timing_ctrl_v2 with CNT_W=6, ADDR_W=4.
module tb_qpsk_timing_ctrl_v2;
  logic clk, rst_n, cic_pulse, clr, mode, arm, marker_in, stamp_ack;
  logic [5:0] cic_pulse_counter, stamp;
  logic [3:0] bram_addr;
  logic bram_we, wrap_pulse, running, done, stamp_valid, stamp_overrun;
  typedef struct {int cnt; int addr; bit wrap;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0, wraps = 0, mcnt = 0;
  qpsk_timing_ctrl_v2 #(.CNT_W(6), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cic_pulse(cic_pulse), .clr(clr), .mode(mode), .arm(arm),
    .marker_in(marker_in), .cic_pulse_counter(cic_pulse_counter), .bram_addr(bram_addr),
    .bram_we(bram_we), .wrap_pulse(wrap_pulse), .running(running), .done(done),
    .stamp(stamp), .stamp_valid(stamp_valid), .stamp_ack(stamp_ack), .stamp_overrun(stamp_overrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (wrap_pulse) wraps++;
      if (bram_we) begin
        if (q.size() == 0) check("bram_we_unexpected", int'(bram_we), 0);
        else begin
          mon_e = q.pop_front();
          check("sb_cnt", int'(cic_pulse_counter), mon_e.cnt);
          check("sb_addr", int'(bram_addr), mon_e.addr);
          check("sb_wrap", int'(wrap_pulse), int'(mon_e.wrap));
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulses(input int n);
    cic_pulse = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!(mcnt == 63 && mode)) begin
        mcnt = (mcnt + 1) % 64;
        if (mcnt % 4 == 0) q.push_back('{mcnt, mcnt / 4, mcnt == 0});
      end
      tick();
    end
    cic_pulse = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; cic_pulse = 1'b0; clr = 1'b0; mode = 1'b0; arm = 1'b0;
    marker_in = 1'b0; stamp_ack = 1'b0;
    #12;
    check("rst_cnt", int'(cic_pulse_counter), 0);
    check("rst_addr", int'(bram_addr), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(bram_we), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_stamp", int'(stamp), 0);
    check("rst_stamp_valid", int'(stamp_valid), 0);
    check("rst_overrun", int'(stamp_overrun), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    check("idle_after_release", int'(running), 0);
    tick();
    check("run_mode0", int'(running), 1);
    check("no_strobe_we", int'(bram_we), 0);
    check("no_strobe_wrap", int'(wrap_pulse), 0);
    mcnt = 0;
    pulses(63);
    check("cnt_63", int'(cic_pulse_counter), 63);
    check("addr_15", int'(bram_addr), 15);
    pulses(1);
    check("wrap_cnt0", int'(cic_pulse_counter), 0);
    check("wrap_addr0", int'(bram_addr), 0);
    check("wrap_pulse_hi", int'(wrap_pulse), 1);
    tick();
    check("wrap_pulse_one_cycle", int'(wrap_pulse), 0);
    check("wraps_1", wraps, 1);
    mode = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_idle", int'(running), 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mcnt = 0;
    check("arm_run", int'(running), 1);
    check("arm_cnt", int'(cic_pulse_counter), 0);
    pulses(63);
    check("os_cnt63", int'(cic_pulse_counter), 63);
    check("os_not_done", int'(done), 0);
    pulses(1);
    check("os_done", int'(done), 1);
    check("os_not_running", int'(running), 0);
    check("os_hold63", int'(cic_pulse_counter), 63);
    pulses(6);
    check("os_frozen", int'(cic_pulse_counter), 63);
    check("os_no_wrap", wraps, 1);
    mode = 1'b0;
    tick();
    tick();
    check("mode_no_leave_done", int'(done), 1);
    mode = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mcnt = 0;
    check("rearm_cnt", int'(cic_pulse_counter), 0);
    check("rearm_running", int'(running), 1);
    pulses(11);
    check("cnt_11", int'(cic_pulse_counter), 11);
    clr = 1'b1;
    cic_pulse = 1'b1;
    tick();
    clr = 1'b0;
    cic_pulse = 1'b0;
    mcnt = 0;
    check("clr_pri_cnt", int'(cic_pulse_counter), 0);
    check("clr_pri_idle", int'(running), 0);
    check("clr_pri_we", int'(bram_we), 0);
    tick();
    check("idle_mode1_stays", int'(running), 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mcnt = 0;
    pulses(10);
    mode = 1'b0;
    pulses(54);
    check("mode_switch_wrap", int'(cic_pulse_counter), 0);
    check("mode_switch_running", int'(running), 1);
    pulses(37);
    marker_in = 1'b1;
    pulses(1);
    check("stamp_cnt38", int'(cic_pulse_counter), 38);
`ifdef QPSK_TIMING_STAMP_EN
    check("stamp_37", int'(stamp), 37);
    check("stamp_valid_1", int'(stamp_valid), 1);
    check("overrun_0", int'(stamp_overrun), 0);
`else
    check("stamp_off", int'(stamp), 0);
    check("stamp_valid_off", int'(stamp_valid), 0);
`endif
    marker_in = 1'b0;
    tick();
    marker_in = 1'b1;
    tick();
`ifdef QPSK_TIMING_STAMP_EN
    check("stamp_kept_37", int'(stamp), 37);
    check("overrun_set", int'(stamp_overrun), 1);
`else
    check("overrun_off", int'(stamp_overrun), 0);
`endif
    clr = 1'b1;
    marker_in = 1'b0;
    tick();
    clr = 1'b0;
    mcnt = 0;
    check("overrun_cleared", int'(stamp_overrun), 0);
    tick();
    pulses(5);
    marker_in = 1'b1;
    stamp_ack = 1'b1;
    tick();
    stamp_ack = 1'b0;
`ifdef QPSK_TIMING_STAMP_EN
    check("ack_edge_stamp5", int'(stamp), 5);
    check("ack_edge_valid", int'(stamp_valid), 1);
`else
    check("ack_edge_valid_off", int'(stamp_valid), 0);
`endif
    check("ack_edge_no_overrun", int'(stamp_overrun), 0);
    marker_in = 1'b0;
    stamp_ack = 1'b1;
    tick();
    stamp_ack = 1'b0;
    check("ack_clears_valid", int'(stamp_valid), 0);
    pulses(2);
    check("pre_rst_cnt7", int'(cic_pulse_counter), 7);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", int'(cic_pulse_counter), 0);
    check("mid_rst_running", int'(running), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_we", int'(bram_we), 0);
    check("mid_rst_wrap", int'(wrap_pulse), 0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    mcnt = 0;
    check("post_rst_idle", int'(running), 0);
    tick();
    check("post_rst_run", int'(running), 1);
    check("post_rst_we", int'(bram_we), 0);
    check("post_rst_wrap", int'(wrap_pulse), 0);
    check("post_rst_cnt", int'(cic_pulse_counter), 0);
    tick();
    check("sb_drained", q.size(), 0);
    check("total_wraps", wraps, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
